// File: rtl/jxfer_ctrl.sv
// Two-port register-to-register transfer sequencer driving one-hot enable/set strobes on a shared bus.
// Optional round-robin tie arbitration is built when JXFER_RR_EN is defined; otherwise port 0 always wins ties.
module jxfer_ctrl #(
  parameter int N  = 2,
  parameter int N2 = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0,
  input  logic [N-1:0]  src0,
  input  logic [N-1:0]  dst0,
  output logic          ack0,
  input  logic          req1,
  input  logic [N-1:0]  src1,
  input  logic [N-1:0]  dst1,
  output logic          ack1,
  output logic [N2-1:0] ben,
  output logic [N2-1:0] bset,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENABLE,
    S_SET,
    S_HOLD,
    S_SKIP
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_gnt;
  logic          w_gnt_next;
  logic [N-1:0]  r_src;
  logic [N-1:0]  r_dst;
  logic [N-1:0]  w_src_next;
  logic [N-1:0]  w_dst_next;
  logic [N2-1:0] w_src_oh;
  logic [N2-1:0] w_dst_oh;
  logic [N2-1:0] r_ben;
  logic [N2-1:0] r_bset;
  logic [N2-1:0] w_ben_next;
  logic [N2-1:0] w_bset_next;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_busy;
  logic          w_ack0_next;
  logic          w_ack1_next;
  logic          w_busy_next;
  logic          w_any_req;
  logic          w_pick1;

  assign w_any_req = req0 | req1;

`ifdef JXFER_RR_EN
  // r_last holds the port granted most recently; a tie goes to the other one.
  logic r_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= 1'b1;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last <= w_pick1;
    end
  end

  assign w_pick1 = req1 & (~req0 | ~r_last);
`else
  assign w_pick1 = req1 & ~req0;
`endif

  // Next-state and operand latch selection.
  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_src_next   = r_src;
    w_dst_next   = r_dst;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_gnt_next   = w_pick1;
          w_src_next   = w_pick1 ? src1 : src0;
          w_dst_next   = w_pick1 ? dst1 : dst0;
          w_state_next = (w_src_next == w_dst_next) ? S_SKIP : S_ENABLE;
        end
      end
      S_ENABLE: w_state_next = S_SET;
      S_SET:    w_state_next = S_HOLD;
      S_HOLD:   w_state_next = S_IDLE;
      S_SKIP:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < N2; gi++) begin : g_dec
    assign w_src_oh[gi] = (int'(w_src_next) == gi);
    assign w_dst_oh[gi] = (int'(w_dst_next) == gi);
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    w_ben_next  = '0;
    w_bset_next = '0;
    w_ack0_next = 1'b0;
    w_ack1_next = 1'b0;
    w_busy_next = (w_state_next != S_IDLE);
    case (w_state_next)
      S_ENABLE: w_ben_next = w_src_oh;
      S_SET: begin
        w_ben_next  = w_src_oh;
        w_bset_next = w_dst_oh;
      end
      S_HOLD: begin
        w_ben_next  = w_src_oh;
        w_ack0_next = ~w_gnt_next;
        w_ack1_next = w_gnt_next;
      end
      S_SKIP: begin
        w_ack0_next = ~w_gnt_next;
        w_ack1_next = w_gnt_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_ben   <= '0;
      r_bset  <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_src   <= w_src_next;
      r_dst   <= w_dst_next;
      r_ben   <= w_ben_next;
      r_bset  <= w_bset_next;
      r_ack0  <= w_ack0_next;
      r_ack1  <= w_ack1_next;
      r_busy  <= w_busy_next;
    end
  end

  assign ben  = r_ben;
  assign bset = r_bset;
  assign ack0 = r_ack0;
  assign ack1 = r_ack1;
  assign busy = r_busy;

endmodule

// File: tb/tb_jxfer_ctrl.sv
// Bench for jxfer_ctrl: transaction-level model checked every cycle plus directed literal expectations.
// Follows JXFER_RR_EN for the expected arbitration order.
module tb_jxfer_ctrl;
  localparam int N  = 2;
  localparam int N2 = 4;

  logic          clk;
  logic          reset_n;
  logic          req0, req1;
  logic [N-1:0]  src0, dst0, src1, dst1;
  logic          ack0, ack1, busy;
  logic [N2-1:0] ben, bset;

  int n_checks = 0;
  int n_pass   = 0;

  jxfer_ctrl #(.N(N), .N2(N2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .src0(src0), .dst0(dst0), .ack0(ack0),
    .req1(req1), .src1(src1), .dst1(dst1), .ack1(ack1),
    .ben(ben), .bset(bset), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [N2-1:0] onehot(input logic [N-1:0] i);
    logic [N2-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic pick(input logic r0, input logic r1, input logic last);
`ifdef JXFER_RR_EN
    return r1 & (~r0 | ~last);
`else
    return r1 & ~r0 & (last | ~last);
`endif
  endfunction

  // Transaction model: m_k counts cycles since the grant edge (1 = first cycle).
  logic         m_act;
  int           m_k;
  logic         m_port;
  logic [N-1:0] m_src, m_dst;
  logic         m_last;
  logic         m_self;
  int           m_len;

  assign m_self = (m_src == m_dst);
  assign m_len  = m_self ? 1 : 3;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act  <= 1'b0;
      m_k    <= 0;
      m_last <= 1'b1;
    end else if (m_act) begin
      if (m_k == m_len) m_act <= 1'b0;
      else              m_k   <= m_k + 1;
    end else if (req0 || req1) begin
      m_act  <= 1'b1;
      m_k    <= 1;
      m_port <= pick(req0, req1, m_last);
      m_last <= pick(req0, req1, m_last);
      m_src  <= pick(req0, req1, m_last) ? src1 : src0;
      m_dst  <= pick(req0, req1, m_last) ? dst1 : dst0;
    end
  end

  logic [N2-1:0] e_ben, e_bset;
  logic          e_ack0, e_ack1, e_busy;
  assign e_ben  = (m_act && !m_self) ? onehot(m_src) : '0;
  assign e_bset = (m_act && !m_self && m_k == 2) ? onehot(m_dst) : '0;
  assign e_ack0 = m_act && (m_k == m_len) && !m_port;
  assign e_ack1 = m_act && (m_k == m_len) && m_port;
  assign e_busy = m_act;

  logic [N2-1:0] prev_ben = '0;
  always @(negedge clk) begin
    chk("ben", 32'(ben), 32'(e_ben));
    chk("bset", 32'(bset), 32'(e_bset));
    chk("ack0", 32'(ack0), 32'(e_ack0));
    chk("ack1", 32'(ack1), 32'(e_ack1));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("ack_excl", 32'(ack0 & ack1), 32'd0);
    chk("onehot", 32'(($countones(ben) <= 1) && ($countones(bset) <= 1)), 32'd1);
    chk("bset_gate", 32'((bset == '0) || (ben != '0 && prev_ben != '0)), 32'd1);
    prev_ben <= ben;
  end

  logic [3:0] order;
  logic [3:0] exp_order;
  int         got;
  bit         seen;

  initial begin
    req0 = 0; req1 = 0; src0 = 0; dst0 = 0; src1 = 0; dst1 = 0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ben", 32'(ben), 0);
    chk("rst_bset", 32'(bset), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'({ack0, ack1}), 0);
    reset_n = 1'b1;
    $display("reset released");

    // Port-0 1->2; operands changed after grant must not matter.
    req0 = 1; src0 = 1; dst0 = 2;
    @(negedge clk);
    chk("x0_c1_ben", 32'(ben), 32'h2);
    chk("x0_c1_bset", 32'(bset), 0);
    chk("x0_c1_busy", 32'(busy), 1);
    src0 = 3; dst0 = 0;
    @(negedge clk);
    chk("x0_c2_ben", 32'(ben), 32'h2);
    chk("x0_c2_bset", 32'(bset), 32'h4);
    @(negedge clk);
    chk("x0_c3_ben", 32'(ben), 32'h2);
    chk("x0_c3_bset", 32'(bset), 0);
    chk("x0_c3_ack0", 32'(ack0), 1);
    req0 = 0;
    @(negedge clk);
    chk("x0_c4_busy", 32'(busy), 0);
    $display("xfer port0 1->2 done");

    // Port-1 self transfer 3->3.
    req1 = 1; src1 = 3; dst1 = 3;
    @(negedge clk);
    chk("x1_c1_ack1", 32'(ack1), 1);
    chk("x1_c1_busy", 32'(busy), 1);
    chk("x1_c1_ben", 32'({ben, bset}), 0);
    req1 = 0;
    @(negedge clk);
    chk("x1_c2_busy", 32'(busy), 0);
    chk("x1_c2_ack1", 32'(ack1), 0);
    $display("xfer port1 3->3 (skip) done");

    // Ties: both held for four transfers.
    req0 = 1; src0 = 0; dst0 = 1;
    req1 = 1; src1 = 2; dst1 = 3;
    got = 0; order = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        order[got] = ack1;
        got++;
        $display("tie transfer %0d granted port %0d", got, ack1);
        if (got == 4) begin req0 = 0; req1 = 0; end
      end
    end
    chk("tie_count", 32'(got), 4);
`ifdef JXFER_RR_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b0000;
`endif
    chk("tie_order", 32'(order), 32'(exp_order));
    req0 = 0; req1 = 0;
    @(negedge clk);
    @(negedge clk);

    // Reset asserted during SET.
    req0 = 1; src0 = 1; dst0 = 2;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (bset != '0) seen = 1;
    end
    chk("rst_mid_reach_set", 32'(seen), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_ben", 32'(ben), 0);
    chk("rst_mid_bset", 32'(bset), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    req0 = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_mid_noack", 32'({ack0, ack1, busy}), 0);
    end
    $display("reset mid-transfer aborted");

    // Late request from port 1 while port 0 is in ENABLE.
    req0 = 1; src0 = 1; dst0 = 2;
    @(negedge clk);
    chk("late_c1_ben", 32'(ben), 32'h2);
    req1 = 1; src1 = 0; dst1 = 3;
    @(negedge clk);
    @(negedge clk);
    chk("late_ack0", 32'(ack0), 1);
    req0 = 0;
    src1 = 2;
    @(negedge clk);
    chk("late_idle_busy", 32'(busy), 0);
    @(negedge clk);
    chk("late_p1_ben", 32'(ben), 32'h4);
    src1 = 1; dst1 = 0;
    @(negedge clk);
    chk("late_p1_bset", 32'(bset), 32'h8);
    @(negedge clk);
    chk("late_p1_ack1", 32'(ack1), 1);
    req1 = 0;
    @(negedge clk);
    @(negedge clk);
    chk("late_end_busy", 32'(busy), 0);
    $display("late request port1 2->3 done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
